// File: rtl/fwd_pkg.sv
// Shared constants, state encoding and width helper for the forwarding/hazard unit.
package fwd_pkg;

  localparam int SEL_RF = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Priority bypass-source match for one ID/EX operand against the forwarding stages.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int NSTG     = 2,
  parameter int ZERO_REG = 0,
  parameter int SELW     = 2
) (
  input  logic                   forward_en_in,
  input  logic [REG_AW-1:0]      src_in,
  input  logic                   src_valid_in,
  input  logic [NSTG-1:0]        stg_wb_en_in,
  input  logic [NSTG*REG_AW-1:0] stg_dest_in,
  output logic [SELW-1:0]        sel_out,
  output logic                   any_match_out
);

  logic [NSTG-1:0] hit;
  logic            zero_src;

  assign zero_src = (ZERO_REG != 0) && (src_in == '0);

  for (genvar s = 0; s < NSTG; s++) begin : g_stg
    assign hit[s] = src_valid_in & stg_wb_en_in[s] & ~zero_src &
                    (stg_dest_in[s*REG_AW +: REG_AW] == src_in);
  end

  assign any_match_out = |hit;

  // Walk oldest to youngest so the youngest matching stage overwrites the select.
  always_comb begin
    sel_out = SELW'(SEL_RF);
    if (forward_en_in) begin
      for (int s = NSTG - 1; s >= 0; s--) begin
        if (hit[s]) sel_out = SELW'(s + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select plus load-use / RAW stall control with stall statistics.
// state | meaning
// IDLE  | no stall in flight; stall decided combinationally from current inputs
// STALL | load-use stall in progress, down-counter holds remaining cycles
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int NSRC     = 2,
  parameter int NSTG     = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic                             clk_in,
  input  logic                             rst_n_in,
  input  logic                             forward_en_in,
  input  logic [NSRC*REG_AW-1:0]           src_in,
  input  logic [NSRC-1:0]                  src_valid_in,
  input  logic                             id_valid_in,
  input  logic                             ex_wb_en_in,
  input  logic                             ex_mem_read_in,
  input  logic [REG_AW-1:0]                ex_dest_in,
  input  logic [NSTG-1:0]                  stg_wb_en_in,
  input  logic [NSTG*REG_AW-1:0]           stg_dest_in,
  input  logic                             flush_in,
  input  logic                             clear_stats_in,
  output logic [NSRC*clog2(NSTG+1)-1:0]    sel_src_out,
  output logic                             stall_out,
  output logic [CNT_W-1:0]                 stall_cycles_out
);

  localparam int SELW = clog2(NSTG + 1);
  localparam int CW   = clog2(LOAD_LAT + 1);

  localparam logic [CW-1:0]    CNT_START = CW'(LOAD_LAT - 1);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [CNT_W-1:0] STATS_ONE = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  stats_q, stats_d;
  logic [NSRC-1:0]   stg_hit;
  logic [NSRC-1:0]   ex_hit;
  logic              lu_haz;
  logic              raw_haz;
  logic              stall;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [REG_AW-1:0] src_a;
    logic              zero_src;

    assign src_a    = src_in[i*REG_AW +: REG_AW];
    assign zero_src = (ZERO_REG != 0) && (src_a == '0);

    fwd_src_match #(
      .REG_AW   (REG_AW),
      .NSTG     (NSTG),
      .ZERO_REG (ZERO_REG),
      .SELW     (SELW)
    ) u_match (
      .forward_en_in (forward_en_in),
      .src_in        (src_a),
      .src_valid_in  (src_valid_in[i]),
      .stg_wb_en_in  (stg_wb_en_in),
      .stg_dest_in   (stg_dest_in),
      .sel_out       (sel_src_out[i*SELW +: SELW]),
      .any_match_out (stg_hit[i])
    );

    assign ex_hit[i] = src_valid_in[i] & ex_wb_en_in & ~zero_src & (ex_dest_in == src_a);
  end

  assign lu_haz  = id_valid_in & forward_en_in & ex_mem_read_in & (|ex_hit);
  assign raw_haz = id_valid_in & ~forward_en_in & ((|ex_hit) | (|stg_hit));

  // Once in STALL the pipeline inputs are ignored until the counter expires.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (forward_en_in) begin
          stall = lu_haz;
          if (lu_haz && (LOAD_LAT > 1)) begin
            state_d = STALL;
            cnt_d   = CNT_START;
          end
        end else begin
          stall = raw_haz;
        end
      end
      STALL: begin
        stall = 1'b1;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_in) begin
      stall   = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_comb begin
    stats_d = stats_q;
    if (clear_stats_in) begin
      stats_d = '0;
    end else if (stall && (stats_q != '1)) begin
      stats_d = stats_q + STATS_ONE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stats_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stats_q <= stats_d;
    end
  end

  assign stall_out        = stall;
  assign stall_cycles_out = stats_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two unit instances (LOAD_LAT=2/ZERO_REG=1/CNT_W=4 and LOAD_LAT=3/ZERO_REG=0/CNT_W=16).
module tb_fwd_hazard_unit;

  localparam int REG_AW = 4;
  localparam int NSRC   = 2;
  localparam int NSTG   = 2;
  localparam int SELW   = 2;

  localparam int SIG_SEL_A   = 0;
  localparam int SIG_SEL_B   = 1;
  localparam int SIG_STALL_A = 2;
  localparam int SIG_STALL_B = 3;
  localparam int SIG_STATS_A = 4;
  localparam int SIG_STATS_B = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                     forward_en;
  logic [NSRC*REG_AW-1:0]   src;
  logic [NSRC-1:0]          src_valid;
  logic                     id_valid;
  logic                     ex_wb_en;
  logic                     ex_mem_read;
  logic [REG_AW-1:0]        ex_dest;
  logic [NSTG-1:0]          stg_wb_en;
  logic [NSTG*REG_AW-1:0]   stg_dest;
  logic                     flush;
  logic                     clear_stats;

  logic [NSRC*SELW-1:0]     sel_a, sel_b;
  logic                     stall_a, stall_b;
  logic [3:0]               stats_a;
  logic [15:0]              stats_b;

  fwd_hazard_unit #(
    .REG_AW(REG_AW), .NSRC(NSRC), .NSTG(NSTG), .LOAD_LAT(2), .ZERO_REG(1), .CNT_W(4)
  ) u_dut_a (
    .clk_in(clk), .rst_n_in(rst_n), .forward_en_in(forward_en), .src_in(src),
    .src_valid_in(src_valid), .id_valid_in(id_valid), .ex_wb_en_in(ex_wb_en),
    .ex_mem_read_in(ex_mem_read), .ex_dest_in(ex_dest), .stg_wb_en_in(stg_wb_en),
    .stg_dest_in(stg_dest), .flush_in(flush), .clear_stats_in(clear_stats),
    .sel_src_out(sel_a), .stall_out(stall_a), .stall_cycles_out(stats_a)
  );

  fwd_hazard_unit #(
    .REG_AW(REG_AW), .NSRC(NSRC), .NSTG(NSTG), .LOAD_LAT(3), .ZERO_REG(0), .CNT_W(16)
  ) u_dut_b (
    .clk_in(clk), .rst_n_in(rst_n), .forward_en_in(forward_en), .src_in(src),
    .src_valid_in(src_valid), .id_valid_in(id_valid), .ex_wb_en_in(ex_wb_en),
    .ex_mem_read_in(ex_mem_read), .ex_dest_in(ex_dest), .stg_wb_en_in(stg_wb_en),
    .stg_dest_in(stg_dest), .flush_in(flush), .clear_stats_in(clear_stats),
    .sel_src_out(sel_b), .stall_out(stall_b), .stall_cycles_out(stats_b)
  );

  typedef struct {
    string       name;
    int          sig;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_SEL_A:   return 32'(sel_a);
      SIG_SEL_B:   return 32'(sel_b);
      SIG_STALL_A: return 32'(stall_a);
      SIG_STALL_B: return 32'(stall_b);
      SIG_STATS_A: return 32'(stats_a);
      SIG_STATS_B: return 32'(stats_b);
      default:     return 'x;
    endcase
  endfunction

  task automatic sb_push(input string name, input int sig, input logic [31:0] v);
    sb_item_t it;
    it.name = name;
    it.sig  = sig;
    it.exp  = v;
    sb.push_back(it);
  endtask

  task automatic set_idle();
    forward_en  = 1'b1;
    src         = '0;
    src_valid   = '0;
    id_valid    = 1'b0;
    ex_wb_en    = 1'b0;
    ex_mem_read = 1'b0;
    ex_dest     = '0;
    stg_wb_en   = '0;
    stg_dest    = '0;
    flush       = 1'b0;
    clear_stats = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sb_item_t it;
    logic [31:0] obs;
    set_idle();
    rst_n = 1'b0;
    sb_push("rst_sel_a", SIG_SEL_A, 32'h0);
    sb_push("rst_sel_b", SIG_SEL_B, 32'h0);
    sb_push("rst_stall_a", SIG_STALL_A, 32'h0);
    sb_push("rst_stall_b", SIG_STALL_B, 32'h0);
    sb_push("rst_stats_a", SIG_STATS_A, 32'h0);
    sb_push("rst_stats_b", SIG_STATS_B, 32'h0);
    @(negedge clk);
    while (sb.size() != 0) begin
      it  = sb.pop_front();
      obs = observe(it.sig);
      n_cmp++;
      if (obs !== it.exp) begin
        n_bad++;
        $display("FAIL %s: got 'h%0h want 'h%0h", it.name, obs, it.exp);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_youngest_wins();
    sb_item_t it;
    logic [31:0] obs;
    logic [31:0] want_sel;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      forward_en = 1'b1;
      id_valid   = 1'b1;
      src        = {4'd5, 4'd3};
      src_valid  = 2'b11;
      ex_wb_en   = 1'b1;
      ex_dest    = 4'd3;
      case (c)
        0: begin stg_dest = {4'd3, 4'd3}; stg_wb_en = 2'b11; want_sel = 32'h1; end
        1: begin stg_dest = {4'd5, 4'd3}; stg_wb_en = 2'b11; want_sel = 32'h9; end
        2: begin stg_dest = {4'd3, 4'd3}; stg_wb_en = 2'b10; want_sel = 32'h2; end
        default: begin
          src_valid = 2'b10; stg_dest = {4'd3, 4'd5}; stg_wb_en = 2'b11; want_sel = 32'h4;
        end
      endcase
      sb_push($sformatf("yw_sel_a_c%0d", c), SIG_SEL_A, want_sel);
      sb_push($sformatf("yw_sel_b_c%0d", c), SIG_SEL_B, want_sel);
      sb_push($sformatf("yw_stall_a_c%0d", c), SIG_STALL_A, 32'h0);
      sb_push($sformatf("yw_stall_b_c%0d", c), SIG_STALL_B, 32'h0);
      @(negedge clk);
      while (sb.size() != 0) begin
        it  = sb.pop_front();
        obs = observe(it.sig);
        n_cmp++;
        if (obs !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got 'h%0h want 'h%0h", it.name, obs, it.exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    sb_item_t it;
    logic [31:0] obs;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      forward_en  = 1'b1;
      id_valid    = 1'b1;
      src         = {4'd7, 4'd0};
      src_valid   = 2'b10;
      ex_wb_en    = 1'b1;
      ex_dest     = 4'd7;
      ex_mem_read = (c == 0);
      stg_dest    = {4'd0, 4'd7};
      stg_wb_en   = (c == 0) ? 2'b01 : 2'b00;
      case (c)
        0: begin
          sb_push("lu_sel_a_with_stall", SIG_SEL_A, 32'h4);
          sb_push("lu_stall_a_c0", SIG_STALL_A, 32'h1);
          sb_push("lu_stall_b_c0", SIG_STALL_B, 32'h1);
        end
        1: begin
          sb_push("lu_stall_a_c1", SIG_STALL_A, 32'h1);
          sb_push("lu_stall_b_c1", SIG_STALL_B, 32'h1);
          sb_push("lu_stats_a_c1", SIG_STATS_A, 32'h1);
        end
        2: begin
          sb_push("lu_stall_a_c2", SIG_STALL_A, 32'h0);
          sb_push("lu_stall_b_c2", SIG_STALL_B, 32'h1);
          sb_push("lu_stats_a_c2", SIG_STATS_A, 32'h2);
        end
        default: begin
          sb_push("lu_stall_a_c3", SIG_STALL_A, 32'h0);
          sb_push("lu_stall_b_c3", SIG_STALL_B, 32'h0);
          sb_push("lu_stats_a_end", SIG_STATS_A, 32'h2);
          sb_push("lu_stats_b_end", SIG_STATS_B, 32'h3);
        end
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        it  = sb.pop_front();
        obs = observe(it.sig);
        n_cmp++;
        if (obs !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got 'h%0h want 'h%0h", it.name, obs, it.exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    sb_item_t it;
    logic [31:0] obs;
    do_reset();
    for (int c = 0; c < 2; c++) begin
      forward_en  = 1'b1;
      id_valid    = 1'b1;
      src         = {4'd0, 4'd0};
      src_valid   = 2'b01;
      stg_dest    = {4'd9, 4'd0};
      stg_wb_en   = 2'b01;
      ex_wb_en    = (c == 1);
      ex_mem_read = (c == 1);
      ex_dest     = 4'd0;
      if (c == 0) begin
        sb_push("zr_sel_a_zero_reg", SIG_SEL_A, 32'h0);
        sb_push("zr_sel_b_no_zero_reg", SIG_SEL_B, 32'h1);
        sb_push("zr_stall_a_c0", SIG_STALL_A, 32'h0);
        sb_push("zr_stall_b_c0", SIG_STALL_B, 32'h0);
      end else begin
        sb_push("zr_lu_stall_a", SIG_STALL_A, 32'h0);
        sb_push("zr_lu_stall_b", SIG_STALL_B, 32'h1);
      end
      @(negedge clk);
      while (sb.size() != 0) begin
        it  = sb.pop_front();
        obs = observe(it.sig);
        n_cmp++;
        if (obs !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got 'h%0h want 'h%0h", it.name, obs, it.exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_no_forward();
    sb_item_t it;
    logic [31:0] obs;
    logic [31:0] want;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      forward_en  = 1'b0;
      id_valid    = (c != 5);
      src         = {4'd1, 4'd4};
      src_valid   = 2'b01;
      stg_dest    = {4'd4, 4'd2};
      stg_wb_en   = (c < 3) ? 2'b10 : 2'b00;
      ex_wb_en    = (c >= 4);
      ex_mem_read = (c >= 4);
      ex_dest     = 4'd4;
      want        = (c < 3 || c == 4) ? 32'h1 : 32'h0;
      sb_push($sformatf("nf_stall_a_c%0d", c), SIG_STALL_A, want);
      sb_push($sformatf("nf_stall_b_c%0d", c), SIG_STALL_B, want);
      if (c == 0) sb_push("nf_sel_a_zero", SIG_SEL_A, 32'h0);
      if (c == 5) begin
        sb_push("nf_stats_a", SIG_STATS_A, 32'h4);
        sb_push("nf_stats_b", SIG_STATS_B, 32'h4);
      end
      @(negedge clk);
      while (sb.size() != 0) begin
        it  = sb.pop_front();
        obs = observe(it.sig);
        n_cmp++;
        if (obs !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got 'h%0h want 'h%0h", it.name, obs, it.exp);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    sb_item_t it;
    logic [31:0] obs;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      forward_en  = 1'b1;
      id_valid    = 1'b1;
      src         = {4'd7, 4'd0};
      src_valid   = 2'b10;
      ex_wb_en    = 1'b1;
      ex_dest     = 4'd7;
      ex_mem_read = (c == 0);
      flush       = (c == 1);
      case (c)
        0: sb_push("fl_stall_b_c0", SIG_STALL_B, 32'h1);
        1: begin
          sb_push("fl_stall_a_flush", SIG_STALL_A, 32'h0);
          sb_push("fl_stall_b_flush", SIG_STALL_B, 32'h0);
        end
        default: begin
          sb_push("fl_stall_a_after", SIG_STALL_A, 32'h0);
          sb_push("fl_stall_b_after", SIG_STALL_B, 32'h0);
          sb_push("fl_stats_a", SIG_STATS_A, 32'h1);
          sb_push("fl_stats_b", SIG_STATS_B, 32'h1);
        end
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        it  = sb.pop_front();
        obs = observe(it.sig);
        n_cmp++;
        if (obs !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got 'h%0h want 'h%0h", it.name, obs, it.exp);
        end
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
  endtask

  task automatic test_stats_and_async_reset();
    sb_item_t it;
    logic [31:0] obs;
    do_reset();
    forward_en = 1'b0;
    id_valid   = 1'b1;
    src        = {4'd0, 4'd4};
    src_valid  = 2'b01;
    stg_dest   = {4'd4, 4'd0};
    stg_wb_en  = 2'b10;
    repeat (21) @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      clear_stats = (c == 1);
      case (c)
        0: begin
          sb_push("st_sat_stats_a", SIG_STATS_A, 32'hF);
          sb_push("st_sat_stats_b", SIG_STATS_B, 32'd21);
          sb_push("st_stall_a_high", SIG_STALL_A, 32'h1);
        end
        1: begin
          sb_push("st_clear_stall_a", SIG_STALL_A, 32'h1);
          sb_push("st_pre_clear_stats_a", SIG_STATS_A, 32'hF);
        end
        default: begin
          sb_push("st_cleared_stats_a", SIG_STATS_A, 32'h0);
          sb_push("st_cleared_stats_b", SIG_STATS_B, 32'h0);
        end
      endcase
      @(negedge clk);
      while (sb.size() != 0) begin
        it  = sb.pop_front();
        obs = observe(it.sig);
        n_cmp++;
        if (obs !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got 'h%0h want 'h%0h", it.name, obs, it.exp);
        end
      end
      @(posedge clk); #1;
    end
    clear_stats = 1'b0;
    sb_push("st_resume_stats_a", SIG_STATS_A, 32'h1);
    forward_en  = 1'b1;
    stg_wb_en   = 2'b00;
    src         = {4'd7, 4'd0};
    src_valid   = 2'b10;
    ex_wb_en    = 1'b1;
    ex_mem_read = 1'b1;
    ex_dest     = 4'd7;
    sb_push("ar_stall_b_hazard", SIG_STALL_B, 32'h1);
    @(negedge clk);
    while (sb.size() != 0) begin
      it  = sb.pop_front();
      obs = observe(it.sig);
      n_cmp++;
      if (obs !== it.exp) begin
        n_bad++;
        $display("FAIL %s: got 'h%0h want 'h%0h", it.name, obs, it.exp);
      end
    end
    @(posedge clk); #1;
    ex_mem_read = 1'b0;
    #1;
    sb_push("ar_stall_b_in_stall", SIG_STALL_B, 32'h1);
    sb_push("ar_stall_a_in_stall", SIG_STALL_A, 32'h1);
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        rst_n = 1'b0;
        #1;
        sb_push("ar_stall_b_reset", SIG_STALL_B, 32'h0);
        sb_push("ar_stall_a_reset", SIG_STALL_A, 32'h0);
        sb_push("ar_stats_b_reset", SIG_STATS_B, 32'h0);
      end
      while (sb.size() != 0) begin
        it  = sb.pop_front();
        obs = observe(it.sig);
        n_cmp++;
        if (obs !== it.exp) begin
          n_bad++;
          $display("FAIL %s: got 'h%0h want 'h%0h", it.name, obs, it.exp);
        end
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_youngest_wins();
    test_load_use();
    test_zero_reg();
    test_no_forward();
    test_flush();
    test_stats_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
